// File: rtl/div_iter_ctrl.sv
// Iterative restoring divider sequencer: one trial subtraction per cycle on a shared
// (DATA_LEN+1)-bit adder, then a sign fix-up cycle that reuses the adder for negation.
module div_iter_ctrl #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                div_valid,
  output logic                div_ready,
  input  logic                div_signed,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder
);

  localparam int CW = $clog2(DATA_LEN);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic                sign_a, sign_b, op_signed;
  logic [DATA_LEN-1:0] a_sh, b_mag, q;
  logic [DATA_LEN:0]   r_part;

  logic                accept, a_neg, b_neg, div_zero, ovf;
  logic [DATA_LEN-1:0] abs_a, abs_b, rem_neg;
  logic [DATA_LEN:0]   add_a, add_b, sum;

  function automatic logic [DATA_LEN:0] add_with_cin(input logic [DATA_LEN:0] a,
                                                     input logic [DATA_LEN:0] b,
                                                     input logic              sub);
    return a + (sub ? ~b : b) + {{DATA_LEN{1'b0}}, sub};
  endfunction

  assign accept   = (state == IDLE) && div_valid && !flush;
  assign a_neg    = div_signed && dividend[DATA_LEN-1];
  assign b_neg    = div_signed && divisor[DATA_LEN-1];
  // |MIN| is 2^(DATA_LEN-1), which is exact when read back as unsigned
  assign abs_a    = a_neg ? -dividend : dividend;
  assign abs_b    = b_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = div_signed && (dividend == {1'b1, {(DATA_LEN-1){1'b0}}}) && (divisor == '1);

  // Shared adder: trial subtract in CALC, 0 - q negation in FIXUP
  always_comb begin
    add_a = {r_part[DATA_LEN-1:0], a_sh[DATA_LEN-1]};
    add_b = {1'b0, b_mag};
    if (state == FIXUP) begin
      add_a = '0;
      add_b = {1'b0, q};
    end
  end

  assign sum     = add_with_cin(add_a, add_b, 1'b1);
  // Remainder negation is needed in the same fix-up cycle as the quotient's
  assign rem_neg = -r_part[DATA_LEN-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (div_zero || ovf) ? DONE : CALC;
      CALC:    if (cnt == CW'(DATA_LEN-1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign div_ready = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      op_signed <= 1'b0;
      a_sh      <= '0;
      b_mag     <= '0;
      q         <= '0;
      r_part    <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (accept) begin
          sign_a    <= a_neg;
          sign_b    <= b_neg;
          op_signed <= div_signed;
          a_sh      <= abs_a;
          b_mag     <= abs_b;
          r_part    <= '0;
          q         <= '0;
          cnt       <= '0;
          if (div_zero) begin
            quotient  <= '1;
            remainder <= dividend;
          end else if (ovf) begin
            quotient  <= dividend;
            remainder <= '0;
          end
        end
        CALC: begin
          a_sh <= a_sh << 1;
          cnt  <= cnt + 1'b1;
          if (!sum[DATA_LEN]) begin
            r_part <= sum;
            q      <= {q[DATA_LEN-2:0], 1'b1};
          end else begin
            r_part <= add_a;
            q      <= {q[DATA_LEN-2:0], 1'b0};
          end
        end
        FIXUP: begin
          quotient  <= (op_signed && (sign_a != sign_b)) ? sum[DATA_LEN-1:0] : q;
          remainder <= (op_signed && sign_a) ? rem_neg : r_part[DATA_LEN-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Directed bench for div_iter_ctrl: latency, signed/unsigned results, special cases,
// backpressure hold, flush and mid-operation reset.
module tb_div_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, div_valid, div_ready, div_signed, out_valid, out_ready;
  logic [31:0] dividend, divisor, quotient, remainder;
  int          n_tests = 0;
  int          n_fail  = 0;

  div_iter_ctrl #(.DATA_LEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .div_valid(div_valid), .div_ready(div_ready),
    .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble inputs after accept, return result and latency
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output int lat);
    @(negedge clk);
    div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; dividend = $urandom; divisor = $urandom; div_signed = ~s;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    q = quotient;
    r = remainder;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0; out_ready = 1'b1;
    #12;
    n_tests++; if (div_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", div_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_tests++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_q got %h exp 0", quotient); end
    n_tests++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_r got %h exp 0", remainder); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_divide();
    logic [31:0] q, r; int lat;
    logic        vs[8];
    logic [31:0] va[8], vb[8], eq[8], er[8];
    int          el[8];
    vs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    va = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C, 32'd5, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    vb = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};
    eq = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    er = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 32'd5, 32'd5, 32'h8000_0000, 32'd0};
    el = '{34, 34, 34, 34, 1, 1, 34, 34};
    for (int i = 0; i < 8; i++) begin
      do_op(vs[i], va[i], vb[i], q, r, lat);
      n_tests++; if (lat != el[i]) begin n_fail++; $display("FAIL div%0d_lat got %0d exp %0d", i, lat, el[i]); end
      n_tests++; if (q !== eq[i]) begin n_fail++; $display("FAIL div%0d_q got %h exp %h", i, q, eq[i]); end
      n_tests++; if (r !== er[i]) begin n_fail++; $display("FAIL div%0d_r got %h exp %h", i, r, er[i]); end
      @(negedge clk);
      n_tests++; if (div_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL div%0d_idle got rdy=%b vld=%b exp rdy=1 vld=0", i, div_ready, out_valid);
      end
    end
  endtask

  task automatic test_special_min();
    logic [31:0] q, r; int lat;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, lat);
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL min_lat got %0d exp 1", lat); end
    n_tests++; if (q !== 32'h8000_0000) begin n_fail++; $display("FAIL min_q got %h exp 80000000", q); end
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL min_r got %h exp 0", r); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] q, r; int lat;
    out_ready = 1'b0;
    do_op(1'b0, 32'd100, 32'd7, q, r, lat);
    n_tests++; if (lat != 34) begin n_fail++; $display("FAIL bp_lat got %0d exp 34", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || div_ready !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
        n_fail++; $display("FAIL bp_hold%0d got vld=%b rdy=%b q=%h r=%h exp 1 0 e 2", i, out_valid, div_ready, quotient, remainder);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || div_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got vld=%b rdy=%b exp 0 1", out_valid, div_ready);
    end
  endtask

  task automatic test_flush();
    logic [31:0] q, r; int lat; int seen;
    @(negedge clk);
    div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; div_valid = 1'b1;
    @(posedge clk); #1; div_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    n_tests++; if (div_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_calc got rdy=%b vld=%b exp 1 0", div_ready, out_valid);
    end
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flush_novalid got %0d exp 0", seen); end
    do_op(1'b0, 32'd9, 32'd3, q, r, lat);
    n_tests++; if (lat != 34 || q !== 32'd3 || r !== 32'd0) begin
      n_fail++; $display("FAIL flush_next got lat=%0d q=%h r=%h exp 34 3 0", lat, q, r);
    end
    @(negedge clk);
    // flush together with a request in IDLE: request is dropped
    div_signed = 1'b0; dividend = 32'd5; divisor = 32'd0; div_valid = 1'b1; flush = 1'b1;
    @(negedge clk); div_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || div_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_idle got vld=%b rdy=%b exp 0 1", out_valid, div_ready);
    end
    // flush beats out_ready=0 in DONE
    out_ready = 1'b0;
    do_op(1'b0, 32'd5, 32'd0, q, r, lat);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; out_ready = 1'b1;
    n_tests++; if (out_valid !== 1'b0 || div_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_done got vld=%b rdy=%b exp 0 1", out_valid, div_ready);
    end
  endtask

  task automatic test_rst_mid_calc();
    logic [31:0] q, r; int lat; int seen;
    do_op(1'b0, 32'd100, 32'd7, q, r, lat);
    @(negedge clk);
    div_signed = 1'b0; dividend = 32'd77; divisor = 32'd5; div_valid = 1'b1;
    @(posedge clk); #1; div_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2; rst = 1'b1; #1;
    n_tests++; if (div_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid got rdy=%b vld=%b q=%h r=%h exp 1 0 0 0", div_ready, out_valid, quotient, remainder);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_novalid got %0d exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_special_min();
    test_backpressure();
    test_flush();
    test_rst_mid_calc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
